gcd_req_master: RTL and testbench
=================================

GCD_REQ_MASTER -- requirements
Module: gcd_req_master

Interface
REQ-001 Parameter W, 16, operand/result width.
REQ-002 Parameter DEPTH, 4, max outstanding requests (power of 2, >=2).
REQ-003 Parameter CNT_W, 8, pass/fail counter width.
REQ-004 Parameter TIMEOUT_CYCLES, 256, watchdog limit (used only with GCD_REQ_TIMEOUT_EN).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 cmd_val / cmd_rdy  in / out  1 / 1  host request handshake.
REQ-008 cmd_bits_A, cmd_bits_B, cmd_bits_expect  in  W each  operands and expected GCD.
REQ-009 operands_val  out  1; operands_rdy  in  1  coprocessor operand handshake.
REQ-010 operands_bits_A, operands_bits_B  out  W  operands to coprocessor.
REQ-011 result_val  in  1; result_rdy  out  1  coprocessor result handshake.
REQ-012 result_bits  in  W  coprocessor result.
REQ-013 pass_count, fail_count  out  CNT_W  compare tallies.
REQ-014 mismatch  out  1  one-cycle pulse on failed compare.
REQ-015 idle  out  1  high when no request held or outstanding.
REQ-016 timeout  out  1  sticky watchdog flag.

Function
REQ-017 Transfer occurs only when val and rdy are both high at a rising edge; the block never drops val or changes bits while val is high and rdy is low.
REQ-018 Issue register holds one operand pair; operands_val registered, asserted the cycle after cmd acceptance (latency 1).
REQ-019 cmd_rdy = (issue register empty OR operand transfer this cycle) AND expect FIFO not full; purely combinational from state and operands_rdy.
REQ-020 On cmd acceptance, cmd_bits_expect is pushed into the expect FIFO in the same edge.
REQ-021 result_rdy = expect FIFO not empty; results arriving with an empty FIFO are not accepted.
REQ-022 On result transfer: pop FIFO head; equal -> pass_count+1; unequal -> fail_count+1 and mismatch high next cycle for one cycle.
REQ-023 Counters saturate at 2^CNT_W-1; no wrap.
REQ-024 Simultaneous cmd acceptance and result transfer: push and pop both take effect; occupancy unchanged; allowed even when FIFO full (pop frees the slot combinationally).
REQ-025 Back-to-back: one cmd accepted per cycle sustained when operands_rdy stays high and FIFO not full.
REQ-026 idle = issue register empty AND FIFO empty.
REQ-027 Comparison is full-width unsigned equality; operands (0,0) with expect 0 are legal.

Reset
REQ-028 Reset clears issue register, FIFO pointers/occupancy, counters, mismatch, timeout; outputs after reset: operands_val=0, cmd_rdy=1, result_rdy=0, idle=1, counts=0.
REQ-029 Reset mid-operation discards all held and outstanding requests; late coprocessor results are not accepted (result_rdy=0).

Configuration
REQ-030 Macro GCD_REQ_TIMEOUT_EN defined: counter counts cycles with FIFO non-empty and no result transfer, clears on result transfer or FIFO empty; reaching TIMEOUT_CYCLES sets timeout until reset.
REQ-031 Macro absent: no watchdog logic; timeout tied 0; TIMEOUT_CYCLES ignored.

Structure
REQ-032 Shared package gcd_pkg holds W default, CNT_W default, and the result-compare outcome enum (CMP_PASS, CMP_FAIL).
REQ-033 Expect storage is a sub-module gcd_req_fifo (synchronous, DEPTH entries, full/empty, same-cycle push/pop).

Verification
REQ-034 Push (12,8,exp 4), responder returns 4 -> operands_val one cycle after accept, pass_count=1, mismatch never high.
REQ-035 Push (15,9,exp 3), responder returns 5 -> fail_count=1, mismatch pulse exactly one cycle.
REQ-036 Push 5 cmds with result_val held low, operands_rdy=1 -> 4 accepted, cmd_rdy low on 5th; one result pops -> 5th accepted same cycle.
REQ-037 operands_rdy low 3 cycles with (200,35) held -> operands_val and bits stable throughout; transfer on 4th cycle.
REQ-038 Reset asserted with 3 outstanding -> next cycle idle=1, counts=0, result_rdy=0.
REQ-039 With GCD_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, one outstanding, no result -> timeout rises after 16 cycles and stays high; without macro timeout stays 0.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared defaults and compare-outcome type for the GCD request master and its expect FIFO.
package gcd_pkg;

  localparam int GCD_W     = 16;
  localparam int GCD_CNT_W = 8;

  typedef enum logic {
    CMP_PASS = 1'b0,
    CMP_FAIL = 1'b1
  } cmp_e;

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous expect-value FIFO with DEPTH entries; a push into a full FIFO is taken when a pop
// happens in the same cycle. The head is read combinationally so a result can be compared on arrival.
module gcd_req_fifo
  import gcd_pkg::*;
#(
  parameter int W     = GCD_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/gcd_req_master.sv
// Test master for a GCD coprocessor: issues operand pairs, queues expected results, tallies compares.
// Optional watchdog enabled with the GCD_REQ_TIMEOUT_EN macro.
module gcd_req_master
  import gcd_pkg::*;
#(
  parameter int W              = GCD_W,
  parameter int DEPTH          = 4,
  parameter int CNT_W          = GCD_CNT_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [W-1:0]     cmd_bits_A,
  input  logic [W-1:0]     cmd_bits_B,
  input  logic [W-1:0]     cmd_bits_expect,
  output logic             operands_val,
  input  logic             operands_rdy,
  output logic [W-1:0]     operands_bits_A,
  output logic [W-1:0]     operands_bits_B,
  input  logic             result_val,
  output logic             result_rdy,
  input  logic [W-1:0]     result_bits,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             mismatch,
  output logic             idle,
  output logic             timeout
);

  logic             r_iss_val;
  logic [W-1:0]     r_iss_a;
  logic [W-1:0]     r_iss_b;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic             r_mismatch;

  logic         w_cmd_fire;
  logic         w_op_fire;
  logic         w_res_fire;
  logic         w_fifo_full;
  logic         w_fifo_empty;
  logic [W-1:0] w_exp_head;
  cmp_e         w_cmp;

  assign w_op_fire  = r_iss_val & operands_rdy;
  assign w_res_fire = result_val & result_rdy;
  assign w_cmd_fire = cmd_val & cmd_rdy;

  // A result pop in the same cycle frees the slot a full FIFO would otherwise block.
  assign cmd_rdy    = (~r_iss_val | operands_rdy) & (~w_fifo_full | w_res_fire);
  assign result_rdy = ~w_fifo_empty;

  gcd_req_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_expect_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_cmd_fire),
    .push_data (cmd_bits_expect),
    .pop       (w_res_fire),
    .head      (w_exp_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_val <= 1'b0;
    end else if (w_cmd_fire) begin
      r_iss_val <= 1'b1;
    end else if (w_op_fire) begin
      r_iss_val <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_a <= '0;
      r_iss_b <= '0;
    end else if (w_cmd_fire) begin
      r_iss_a <= cmd_bits_A;
      r_iss_b <= cmd_bits_B;
    end
  end

  assign w_cmp = (result_bits == w_exp_head) ? CMP_PASS : CMP_FAIL;

  // Tallies saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pass     <= '0;
      r_fail     <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= w_res_fire & (w_cmp == CMP_FAIL);
      if (w_res_fire && (w_cmp == CMP_PASS) && (r_pass != {CNT_W{1'b1}}))
        r_pass <= r_pass + 1'b1;
      if (w_res_fire && (w_cmp == CMP_FAIL) && (r_fail != {CNT_W{1'b1}}))
        r_fail <= r_fail + 1'b1;
    end
  end

`ifdef GCD_REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;

  // Counts stalled cycles with work outstanding; the flag latches once the limit is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_res_fire || w_fifo_empty) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
      r_timeout <= 1'b1;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  // Without the watchdog the flag is constant low for any positive limit.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign operands_val    = r_iss_val;
  assign operands_bits_A = r_iss_a;
  assign operands_bits_B = r_iss_b;
  assign pass_count      = r_pass;
  assign fail_count      = r_fail;
  assign mismatch        = r_mismatch;
  assign idle            = ~r_iss_val & w_fifo_empty;

endmodule

// File: tb/tb_gcd_req_master.sv
// Directed self-checking bench for gcd_req_master; the coprocessor side is driven by hand.
module tb_gcd_req_master;

  localparam int W     = 16;
  localparam int CNT_W = 8;

`ifdef GCD_REQ_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_val;
  logic             cmd_rdy;
  logic [W-1:0]     cmd_bits_A;
  logic [W-1:0]     cmd_bits_B;
  logic [W-1:0]     cmd_bits_expect;
  logic             operands_val;
  logic             operands_rdy;
  logic [W-1:0]     operands_bits_A;
  logic [W-1:0]     operands_bits_B;
  logic             result_val;
  logic             result_rdy;
  logic [W-1:0]     result_bits;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             mismatch;
  logic             idle;
  logic             timeout;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  gcd_req_master #(
    .W              (W),
    .DEPTH          (4),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_val         (cmd_val),
    .cmd_rdy         (cmd_rdy),
    .cmd_bits_A      (cmd_bits_A),
    .cmd_bits_B      (cmd_bits_B),
    .cmd_bits_expect (cmd_bits_expect),
    .operands_val    (operands_val),
    .operands_rdy    (operands_rdy),
    .operands_bits_A (operands_bits_A),
    .operands_bits_B (operands_bits_B),
    .result_val      (result_val),
    .result_rdy      (result_rdy),
    .result_bits     (result_bits),
    .pass_count      (pass_count),
    .fail_count      (fail_count),
    .mismatch        (mismatch),
    .idle            (idle),
    .timeout         (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("[%0t] check %s = %0d ok", $time, tag, obs);
    end else begin
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("%s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic v, input int a, input int b, input int e);
    cmd_val         = v;
    cmd_bits_A      = W'(a);
    cmd_bits_B      = W'(b);
    cmd_bits_expect = W'(e);
  endtask

  initial begin
    reset        = 1'b1;
    operands_rdy = 1'b0;
    result_val   = 1'b0;
    result_bits  = '0;
    set_cmd(1'b0, 0, 0, 0);
    repeat (2) tick();
    reset = 1'b0;
    settle();

    // Reset state
    check("rst_operands_val", operands_val, 0);
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_result_rdy", result_rdy, 0);
    check("rst_idle", idle, 1);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_timeout", timeout, 0);

    // Passing compare: (12,8) expect 4
    set_cmd(1'b1, 12, 8, 4);
    settle();
    check("p_cmd_rdy", cmd_rdy, 1);
    check("p_opval_before", operands_val, 0);
    tick();
    set_cmd(1'b0, 0, 0, 0);
    settle();
    check("p_opval_lat1", operands_val, 1);
    check("p_op_a", operands_bits_A, 12);
    check("p_op_b", operands_bits_B, 8);
    check("p_result_rdy", result_rdy, 1);
    check("p_idle_busy", idle, 0);
    operands_rdy = 1'b1;
    tick();
    settle();
    check("p_opval_drop", operands_val, 0);
    result_val  = 1'b1;
    result_bits = 16'd4;
    tick();
    result_val = 1'b0;
    settle();
    check("p_pass", pass_count, 1);
    check("p_fail", fail_count, 0);
    check("p_mismatch0", mismatch, 0);
    check("p_idle", idle, 1);
    tick();
    settle();
    check("p_mismatch1", mismatch, 0);

    // Failing compare: (15,9) expect 3, responder returns 5
    set_cmd(1'b1, 15, 9, 3);
    tick();
    set_cmd(1'b0, 0, 0, 0);
    settle();
    check("f_opval", operands_val, 1);
    tick();
    result_val  = 1'b1;
    result_bits = 16'd5;
    tick();
    result_val = 1'b0;
    settle();
    check("f_mismatch_hi", mismatch, 1);
    check("f_fail", fail_count, 1);
    check("f_pass", pass_count, 1);
    tick();
    settle();
    check("f_mismatch_lo", mismatch, 0);

    // Fill the expect FIFO, then a pop lets the fifth command in the same cycle
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 20 + i, 30 + i, i + 1);
      settle();
      check($sformatf("fill_rdy%0d", i), cmd_rdy, 1);
      tick();
    end
    set_cmd(1'b1, 24, 34, 5);
    settle();
    check("full_rdy", cmd_rdy, 0);
    tick();
    settle();
    check("full_hold_rdy", cmd_rdy, 0);
    check("full_opval", operands_val, 0);
    result_val  = 1'b1;
    result_bits = 16'd1;
    settle();
    check("pop_frees_rdy", cmd_rdy, 1);
    tick();
    result_val = 1'b0;
    set_cmd(1'b0, 0, 0, 0);
    settle();
    check("full_again_rdy", cmd_rdy, 0);
    check("fifth_op_a", operands_bits_A, 24);
    check("fill_pass", pass_count, 2);
    for (int j = 2; j <= 5; j++) begin
      result_val  = 1'b1;
      result_bits = W'(j);
      tick();
    end
    result_val = 1'b0;
    settle();
    check("drain_pass", pass_count, 6);
    check("drain_fail", fail_count, 1);
    check("drain_idle", idle, 1);

    // Operand backpressure: (200,35) held three cycles
    operands_rdy = 1'b0;
    set_cmd(1'b1, 200, 35, 5);
    tick();
    set_cmd(1'b0, 0, 0, 0);
    settle();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_val%0d", k), operands_val, 1);
      check($sformatf("bp_a%0d", k), operands_bits_A, 200);
      check($sformatf("bp_b%0d", k), operands_bits_B, 35);
      check($sformatf("bp_cmd_rdy%0d", k), cmd_rdy, 0);
      tick();
      settle();
    end
    operands_rdy = 1'b1;
    set_cmd(1'b1, 21, 14, 7);
    settle();
    check("bp_release_a", operands_bits_A, 200);
    check("bp_release_rdy", cmd_rdy, 1);
    tick();
    set_cmd(1'b0, 0, 0, 0);
    settle();
    check("bp_next_val", operands_val, 1);
    check("bp_next_a", operands_bits_A, 21);
    tick();
    settle();
    check("bp_empty_val", operands_val, 0);
    result_val  = 1'b1;
    result_bits = 16'd5;
    tick();
    result_bits = 16'd7;
    tick();
    result_val = 1'b0;
    settle();
    check("bp_pass", pass_count, 8);

    // Reset with three requests outstanding; a late result must be ignored
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, 9, 9, 9);
      tick();
    end
    set_cmd(1'b0, 0, 0, 0);
    settle();
    check("mid_idle", idle, 0);
    reset       = 1'b1;
    result_val  = 1'b1;
    result_bits = 16'd9;
    tick();
    reset = 1'b0;
    settle();
    check("mr_idle", idle, 1);
    check("mr_pass", pass_count, 0);
    check("mr_fail", fail_count, 0);
    check("mr_result_rdy", result_rdy, 0);
    check("mr_opval", operands_val, 0);
    check("mr_cmd_rdy", cmd_rdy, 1);
    tick();
    result_val = 1'b0;
    settle();
    check("mr_late_pass", pass_count, 0);

    // Watchdog: one outstanding request, no result
    set_cmd(1'b1, 48, 18, 6);
    tick();
    set_cmd(1'b0, 0, 0, 0);
    repeat (15) tick();
    settle();
    check("wd_before", timeout, 0);
    tick();
    settle();
    check("wd_at_limit", timeout, EXP_TO);
    result_val  = 1'b1;
    result_bits = 16'd6;
    tick();
    result_val = 1'b0;
    repeat (3) tick();
    settle();
    check("wd_sticky", timeout, EXP_TO);
    check("wd_pass", pass_count, 1);

    // Saturation with back-to-back (0,0) expect 0 and simultaneous push/pop
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("sat_rst_timeout", timeout, 0);
    set_cmd(1'b1, 0, 0, 0);
    result_val  = 1'b1;
    result_bits = 16'd0;
    repeat (300) tick();
    set_cmd(1'b0, 0, 0, 0);
    result_val = 1'b0;
    settle();
    check("sat_pass", pass_count, 255);
    check("sat_fail", fail_count, 0);
    check("sat_mismatch", mismatch, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
